// File: rtl/qr_pkg.sv
// Shared frame-buffer read path definitions: geometry, read latency and requester IDs.
// The arbiter and its tag delay line both build on these.
package qr_pkg;

  localparam int ADDR_W       = 20;
  localparam int DATA_W       = 1;
  localparam int READ_LATENCY = 2;
  localparam int NUM_REQ      = 2;

  typedef enum logic {
    REQ_DOWNSAMPLE = 1'b0,
    REQ_FINDER     = 1'b1
  } req_id_e;

  function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_e id);
    return (id == REQ_FINDER) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/frame_read_arbiter_if.sv
// Bundle between the two frame-buffer readers, the frame writer hold line and the BRAM read port.
// Handshake: req_in[i] is the valid, gnt_out[i] the accept; a read transfers in a cycle where both
// are high, and rvalid_out[i] returns its data exactly READ_LATENCY cycles later.
interface frame_read_arbiter_if #(
  parameter int ADDR_W = qr_pkg::ADDR_W,
  parameter int DATA_W = qr_pkg::DATA_W
);
  import qr_pkg::*;

  logic [NUM_REQ-1:0] req_in;
  logic [ADDR_W-1:0]  addr0_in;
  logic [ADDR_W-1:0]  addr1_in;
  logic               hold_in;
  logic [NUM_REQ-1:0] gnt_out;
  logic [ADDR_W-1:0]  bram_addr_out;
  logic [DATA_W-1:0]  bram_data_in;
  logic [NUM_REQ-1:0] rvalid_out;
  logic [DATA_W-1:0]  rdata_out;
  logic               busy_out;
  logic               dbg_ptr_out;

  modport slave (
    input  req_in, addr0_in, addr1_in, hold_in, bram_data_in,
    output gnt_out, bram_addr_out, rvalid_out, rdata_out, busy_out, dbg_ptr_out
  );

  modport master (
    output req_in, addr0_in, addr1_in, hold_in, bram_data_in,
    input  gnt_out, bram_addr_out, rvalid_out, rdata_out, busy_out, dbg_ptr_out
  );

endinterface

// File: rtl/tag_pipe.sv
// Fixed-depth delay line of (valid, requester ID) tags that tracks reads in flight
// through the BRAM so returned data can be steered to the requester that issued it.
module tag_pipe #(
  parameter int DEPTH = qr_pkg::READ_LATENCY
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           push_valid_in,
  input  qr_pkg::req_id_e push_id_in,
  output logic           pop_valid_out,
  output qr_pkg::req_id_e pop_id_out,
  output logic           busy_out
);
  import qr_pkg::*;

  logic [DEPTH-1:0] valid_q;
  req_id_e          id_q [DEPTH];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) id_q[i] <= REQ_DOWNSAMPLE;
    end else begin
      valid_q[0] <= push_valid_in;
      id_q[0]    <= push_id_in;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
    end
  end

  assign pop_valid_out = valid_q[DEPTH-1];
  assign pop_id_out    = id_q[DEPTH-1];
  assign busy_out      = |valid_q;

endmodule

// File: rtl/frame_read_arbiter.sv
// Round-robin arbiter sharing one frame-buffer read port between the downsampler and the
// finder scanner; the frame writer can stall new grants via hold_in without losing returns.
module frame_read_arbiter #(
  parameter int ADDR_W       = qr_pkg::ADDR_W,
  parameter int DATA_W       = qr_pkg::DATA_W,
  parameter int READ_LATENCY = qr_pkg::READ_LATENCY
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  frame_read_arbiter_if.slave bus
);
  import qr_pkg::*;

  req_id_e            ptr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [NUM_REQ-1:0] gnt;
  logic               grant_any;
  req_id_e            grant_id;
  logic [ADDR_W-1:0]  addr_sel;
  logic               pop_valid;
  req_id_e            pop_id;
  logic               pipe_busy;
  logic [DATA_W-1:0]  rdata_w;

  // Grant is purely combinational so a lone request is served in the cycle it appears.
  always_comb begin
    gnt = '0;
    if (rst_n_in && !bus.hold_in) begin
      case (bus.req_in)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (ptr_q == REQ_FINDER) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign grant_any = |gnt;
  assign grant_id  = gnt[1] ? REQ_FINDER : REQ_DOWNSAMPLE;
  assign addr_sel  = gnt[1] ? bus.addr1_in : bus.addr0_in;

  // ptr_q names the requester that wins a tie; it flips away from whoever was just served.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr_q  <= REQ_DOWNSAMPLE;
      addr_q <= '0;
    end else if (grant_any) begin
      ptr_q  <= (grant_id == REQ_FINDER) ? REQ_DOWNSAMPLE : REQ_FINDER;
      addr_q <= addr_sel;
    end
  end

  tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .push_valid_in (grant_any),
    .push_id_in    (grant_id),
    .pop_valid_out (pop_valid),
    .pop_id_out    (pop_id),
    .busy_out      (pipe_busy)
  );

  assign rdata_w = bus.bram_data_in;

  assign bus.gnt_out       = gnt;
  assign bus.bram_addr_out = grant_any ? addr_sel : addr_q;
  assign bus.rvalid_out    = pop_valid ? id_onehot(pop_id) : '0;
  assign bus.rdata_out     = rdata_w;
  assign bus.busy_out      = pipe_busy;
  assign bus.dbg_ptr_out   = ptr_q;

endmodule

// File: doc/frame_read_arbiter.md
FRAME_READ_ARBITER -- requirements
Module: frame_read_arbiter

Interface
REQ-001 Parameter ADDR_W, default 20, frame-buffer word address width.
REQ-002 Parameter DATA_W, default 1, frame-buffer read data width (binarized pixel).
REQ-003 Parameter READ_LATENCY, default 2, cycles from address presentation to BRAM data valid; legal range 1..4.
REQ-004 clk_in  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n_in  input  1  asynchronous, active-low reset.
REQ-006 req_in  input  2  per-requester read request; bit 0 = downsampler, bit 1 = finder scanner.
REQ-007 addr0_in, addr1_in  input  ADDR_W each  read address; held stable while the matching req_in bit is high.
REQ-008 hold_in  input  1  frame writer owns the port; no grants while high.
REQ-009 gnt_out  output  2  one-hot or zero; the request is accepted this cycle.
REQ-010 bram_addr_out  output  ADDR_W  address to the frame-buffer read port.
REQ-011 bram_data_in  input  DATA_W  frame-buffer read data, READ_LATENCY cycles after its address.
REQ-012 rvalid_out  output  2  one-cycle pulse per requester marking returned data.
REQ-013 rdata_out  output  DATA_W  returned data, valid when any rvalid_out bit is high.
REQ-014 busy_out  output  1  high while any read is in flight.

Function
REQ-015 gnt_out shall be combinational from req_in, hold_in and the registered priority pointer; at most one bit high.
REQ-016 hold_in high shall force gnt_out = 00 the same cycle; in-flight reads still complete and return.
REQ-017 A single request shall be granted in the cycle it is seen, with no idle cycle.
REQ-018 When both bits request, the requester named by the priority pointer shall be granted; the pointer then moves to the other requester (round-robin).
REQ-019 The pointer shall update only on a grant; it is unchanged by idle or held cycles.
REQ-020 bram_addr_out shall equal the granted requester's address in the grant cycle and hold its last value otherwise.
REQ-021 Each grant shall push its requester ID into a READ_LATENCY-deep tag pipeline; an empty slot is pushed when there is no grant.
REQ-022 rvalid_out[i] shall pulse exactly READ_LATENCY cycles after gnt_out[i]; rdata_out = bram_data_in that cycle.
REQ-023 Back-to-back grants (one per cycle) shall be sustained, with returns in grant order and none dropped or duplicated.
REQ-024 A requester that holds req high continuously shall receive a grant at least every second cycle while hold_in is low.
REQ-025 busy_out shall be high when any tag-pipeline slot is occupied.
REQ-026 A requester that deasserts req before its grant shall receive no rvalid for that request; withdrawal is legal.

Reset
REQ-027 rst_n_in low shall clear the tag pipeline, force rvalid_out = 00, busy_out = 0, bram_addr_out = 0 and set the pointer to requester 0, regardless of the clock.
REQ-028 gnt_out shall be 00 while rst_n_in is low.
REQ-029 Reads in flight when reset asserts shall be discarded with no rvalid; the first grant may occur in the first clock after deassertion.

Structure
REQ-030 The shared package qr_pkg shall hold READ_LATENCY, ADDR_W, the requester-ID enum (REQ_DOWNSAMPLE, REQ_FINDER) and a NUM_REQ = 2 constant.
REQ-031 The tag delay line shall be a separate sub-module, tag_pipe (parameterised depth, valid + ID per slot, async active-low reset).
REQ-032 No other sub-modules; arbitration and muxing shall be in frame_read_arbiter.

Verification
REQ-033 Only req_in=01, addr0=0x00123 for 1 cycle -> gnt_out=01, bram_addr_out=0x00123 the same cycle, rvalid_out=01 2 cycles later with rdata = model[0x123].
REQ-034 req_in=11 held 6 cycles after reset -> grants alternate 01,10,01,10,01,10; rvalid pattern is identical, delayed by 2.
REQ-035 req_in=11 with hold_in=1 for cycles 2-4 -> gnt_out=00 in those cycles, pointer unchanged, earlier in-flight rvalids still arrive.
REQ-036 Grant at cycle N, rst_n_in pulsed low at N+1 (mid-cycle) -> no rvalid at N+2, busy_out=0 immediately, next grant goes to requester 0.
REQ-037 READ_LATENCY=4, random req/addr/hold for 10k cycles -> scoreboard shows every grant returns exactly once, in order, to the correct requester with the correct data.
